// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads, buffers words for IF/ID.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_discarded counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PC_STEP    = 4,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] pc_out,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
`endif
  output logic [31:0] instruction
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     pc_mem   [FIFO_DEPTH];
  logic [31:0]     word_mem [FIFO_DEPTH];
  logic [31:0]     rq_pc    [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rq_rd, rq_wr;
  logic [CW-1:0]   count, outstanding, discard, inflight;
  logic [CW:0]     used;
  logic [31:0]     pc_hold;
  logic            accept, resp, drop, push, pop;

  assign used      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = (state == RUN) & ~redirect & (used < DEPTH_L);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & imem_gnt;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp      = imem_rvalid & (outstanding != '0);
  assign drop      = resp & (discard != '0);
  assign push      = resp & (discard == '0) & ~redirect;
  assign pop       = valid & ~stall & ~redirect;
  assign inflight  = outstanding + CW'(accept) - CW'(resp);

  assign valid       = (count != '0);
  assign pc_out      = valid ? pc_mem[rd_ptr] : pc_hold;
  assign instruction = valid ? word_mem[rd_ptr] : 32'h0000_0000;

  // Storage stage: FIFO payload and request-PC shadow are data, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rq_pc[rq_rd];
      word_mem[wr_ptr] <= imem_rdata;
    end
    if (accept) rq_pc[rq_wr] <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      // Responses still owed after this edge must be swallowed once they land.
      outstanding <= inflight;
      discard     <= inflight;
      rq_rd       <= '0;
      rq_wr       <= inflight[AW-1:0];
      pc_hold     <= 32'h0000_0000;
    end else begin
      state       <= RUN;
      pc_hold     <= pc_out;
      outstanding <= inflight;
      if (accept) begin
        fetch_pc <= fetch_pc + 32'(PC_STEP);
        rq_wr    <= rq_wr + 1'b1;
      end
      if (resp) rq_rd <= rq_rd + 1'b1;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= outstanding - CW'(resp);
      end else begin
        if (drop) discard <= discard - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [31:0] lost;
  assign lost = redirect ? (32'(count) + 32'(resp)) : 32'(drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      perf_fetched   <= sat_add(perf_fetched, 32'(push));
      perf_discarded <= sat_add(perf_discarded, lost);
    end
  end
`endif

  always @(posedge clk) begin
    if (!rst) assert (!(imem_rvalid && outstanding == '0));
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model, directed scenarios and random traffic.
module tb_fetch_stage;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, pc_out, instruction;
  logic        imem_req, valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  fetch_stage #(.RESET_PC(RPC), .PC_STEP(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .valid(valid), .pc_out(pc_out),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_discarded(perf_discarded),
`endif
    .instruction(instruction)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; bit dead;} fly_t;
  fly_t        m_fly[$];
  logic [31:0] m_qpc[$], m_qw[$], seen[$];
  logic [31:0] m_fetch, m_last, pend_d;
  bit          m_boot, chk_en, pend_v;
  int          m_pf, m_pd, n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (seen.size() > i) ? seen[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step(input bit st, input bit rd, input logic [31:0] rdpc, input bit g, input bit r);
    bit e_req, e_valid, acc, live;
    logic [31:0] e_pc, e_ins, rdat, addr;
    fly_t f;
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_pc = rdpc; imem_gnt = g;
    imem_rvalid = pend_v; imem_rdata = pend_d;
    #1;
    e_valid = (m_qpc.size() != 0);
    e_pc    = e_valid ? m_qpc[0] : m_last;
    e_ins   = e_valid ? m_qw[0] : 32'h0;
    e_req   = !m_boot && !rd && (m_qpc.size() + m_fly.size() < DEPTH);
    if (chk_en) begin
      check("valid", 32'(valid), 32'(e_valid));
      check("pc_out", pc_out, e_pc);
      check("instruction", instruction, e_ins);
      check("imem_req", 32'(imem_req), 32'(e_req));
      check("imem_addr", imem_addr, m_fetch);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, 32'(m_pf));
      check("perf_discarded", perf_discarded, 32'(m_pd));
`endif
    end
    if (!r && !st && !rd && valid) seen.push_back(pc_out);
    acc = e_req && g;
    addr = m_fetch;
    rdat = pend_d;
    live = pend_v;
    f = '{pc: 32'h0, dead: 1'b1};
    @(posedge clk);
    if (live && m_fly.size() != 0) f = m_fly.pop_front();
    if (r) begin
      if (acc) m_fly.push_back('{pc: addr, dead: 1'b1});
      foreach (m_fly[i]) m_fly[i].dead = 1'b1;
      m_qpc.delete(); m_qw.delete();
      m_fetch = RPC; m_boot = 1'b1; m_last = 32'h0; m_pf = 0; m_pd = 0;
    end else begin
      if (e_valid && !st && !rd) begin
        void'(m_qpc.pop_front()); void'(m_qw.pop_front());
      end
      if (live) begin
        if (!f.dead && !rd) begin
          m_qpc.push_back(f.pc); m_qw.push_back(rdat); m_pf++;
        end else m_pd++;
      end
      if (rd) begin
        m_pd += m_qpc.size();
        m_qpc.delete(); m_qw.delete();
        foreach (m_fly[i]) m_fly[i].dead = 1'b1;
        m_fetch = rdpc;
      end
      if (acc) begin
        m_fly.push_back('{pc: addr, dead: 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
      m_last = e_pc; m_boot = 1'b0;
    end
    pend_v = acc;
    pend_d = addr ^ 32'hA5A5_A5A5;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; chk_en = 0; pend_v = 0; pend_d = 0;
    m_fetch = RPC; m_last = 0; m_boot = 1; m_pf = 0; m_pd = 0;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0;

    step(0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0, 1);
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_ins", instruction, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, RPC);

    // Sequential fetch, memory always grants
    seen.delete();
    repeat (3) step(0, 0, 0, 1, 0);
    #1;
    check("first_valid", 32'(valid), 32'h1);
    check("first_pc", pc_out, 32'h0);
    check("first_ins", instruction, 32'hA5A5_A5A5);
    repeat (10) step(0, 0, 0, 1, 0);
    check("seq_pc1", seen_at(1), 32'h4);
    check("seq_pc2", seen_at(2), 32'h8);
    check("seq_pc3", seen_at(3), 32'hC);

    // Stall holds the head; no gap or duplicate afterwards
    step(0, 0, 0, 1, 0);
    repeat (5) step(1, 0, 0, 1, 0);
    seen.delete();
    repeat (8) step(0, 0, 0, 1, 0);
    check("stall_next", seen_at(1), seen_at(0) + 32'd4);
    check("stall_next2", seen_at(2), seen_at(0) + 32'd8);

    // Redirect with a response in flight
    step(0, 0, 0, 1, 0);
    seen.delete();
    step(0, 1, 32'h100, 1, 0);
    repeat (6) step(0, 0, 0, 1, 0);
    check("redir_pc0", seen_at(0), 32'h100);
    check("redir_pc1", seen_at(1), 32'h104);

    // Redirect together with stall while the buffer is full
    repeat (4) step(1, 0, 0, 1, 0);
    step(1, 1, 32'h200, 1, 0);
    seen.delete();
    repeat (6) step(0, 0, 0, 1, 0);
    check("redir_stall_pc", seen_at(0), 32'h200);

    // Address wrap
    seen.delete();
    step(0, 1, 32'hFFFF_FFF8, 1, 0);
    repeat (9) step(0, 0, 0, 1, 0);
    check("wrap_pc0", seen_at(0), 32'hFFFF_FFF8);
    check("wrap_pc1", seen_at(1), 32'hFFFF_FFFC);
    check("wrap_pc2", seen_at(2), 32'h0000_0000);

    // Toggling grant, reset asserted mid-stream with a grant in the reset cycle
    for (int i = 0; i < 6; i++) step(0, 0, 0, (i % 2) == 0, 0);
    step(0, 0, 0, 1, 1);
    #1;
    check("mrst_valid", 32'(valid), 32'h0);
    check("mrst_pc", pc_out, 32'h0);
    check("mrst_ins", instruction, 32'h0);
    check("mrst_addr", imem_addr, RPC);
`ifdef FETCH_PERF_EN
    check("mrst_pf", perf_fetched, 32'h0);
    check("mrst_pd", perf_discarded, 32'h0);
`endif
    seen.delete();
    for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2) == 1, 0);
    check("mrst_first_pc", seen_at(0), RPC);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00};
      step($urandom % 4 == 0, $urandom % 12 == 0, tgt, $urandom % 3 != 0, $urandom % 150 == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
